// File: rtl/elev_pkg.sv
// Shared elevator encodings: motor command values, floor count and floor index type.
// The controller and the shaft model both import this so the ac encoding lives in one place.
package elev_pkg;

   localparam logic [1:0] AC_DOWN    = 2'd0;
   localparam logic [1:0] AC_STOP    = 2'd1;
   localparam logic [1:0] AC_UP      = 2'd2;
   localparam logic [1:0] AC_ILLEGAL = 2'd3;

   localparam int NUM_FLOORS = 4;

   typedef logic [2:0] floor_t;

endpackage

// File: rtl/shaft_sensor_model_door.sv
// Door dwell timer: detects the rising edge of the door command and holds
// door_busy high for DOOR_CYC cycles; a new rising edge restarts the dwell.
module door_dwell_timer
   import elev_pkg::*;
#(
   parameter int DOOR_CYC = 4
) (
   input  logic clk,
   input  logic ff_reset,
   input  logic open,
   output logic door_busy
);

   localparam int TMR_W = $clog2(DOOR_CYC + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DOOR_CYC);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

   logic             open_q_reg;
   logic [TMR_W-1:0] timer_reg;
   logic [TMR_W-1:0] timer_next;

   always_comb begin
      timer_next = timer_reg;
      if (open && !open_q_reg) begin
         timer_next = TMR_LOAD;
      end else if (timer_reg != '0) begin
         timer_next = timer_reg - TMR_ONE;
      end
   end

   always_ff @(posedge clk or posedge ff_reset) begin
      if (ff_reset) begin
         open_q_reg <= 1'b0;
         timer_reg  <= '0;
      end else begin
         open_q_reg <= open;
         timer_reg  <= timer_next;
      end
   end

   assign door_busy = (timer_reg != '0);

endmodule

// File: rtl/shaft_sensor_model.sv
// Cycle-accurate car/hoistway model: integrates motor commands into a floor+segment
// offset and drives the floor-alignment sensors, arrival pulse and protocol fault.
module shaft_sensor_model
   import elev_pkg::*;
#(
   parameter int TRAVEL_CYC = 8,
   parameter int DOOR_CYC   = 4,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       ff_reset,
   input  logic [1:0] ac,
   input  logic       open,
   output logic       s1,
   output logic       s2,
   output logic       s3,
   output logic       s4,
   output logic       arrive,
   output logic [2:0] pos,
   output logic       moving,
   output logic       door_busy,
   output logic       fault
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRAVEL_CYC - 1);
   localparam floor_t           FLOOR_BOTTOM = floor_t'(1);
   localparam floor_t           FLOOR_TOP    = floor_t'(NUM_FLOORS);

   floor_t           pos_reg, pos_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             arrive_reg, arrive_next;
   logic             moving_reg, moving_next;
   logic             fault_reg, fault_next;
   logic             aligned;
   logic             at_top;
   logic [NUM_FLOORS-1:0] s_vec;

   assign aligned = (cnt_reg == '0);
   assign at_top  = aligned && (pos_reg == FLOOR_TOP);

   always_comb begin
      pos_next   = pos_reg;
      cnt_next   = cnt_reg;
      fault_next = fault_reg;
      unique case (ac)
         AC_UP: begin
            if (at_top) begin
               fault_next = 1'b1;
            end else if (cnt_reg == CNT_LAST) begin
               pos_next = pos_reg + floor_t'(1);
               cnt_next = '0;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         AC_DOWN: begin
            // Idling at the bottom with ac=down is the controller's normal reset state.
            if (!aligned) begin
               cnt_next = cnt_reg - CNT_ONE;
            end else if (pos_reg > FLOOR_BOTTOM) begin
               pos_next = pos_reg - floor_t'(1);
               cnt_next = CNT_LAST;
            end
         end
         AC_STOP: begin
         end
         default: begin
            fault_next = 1'b1;
         end
      endcase
      // Door may only open while halted and aligned.
      if (open && (!aligned || ac != AC_STOP)) begin
         fault_next = 1'b1;
      end
      moving_next = (pos_next != pos_reg) || (cnt_next != cnt_reg);
      arrive_next = (cnt_next == '0) && !aligned;
   end

   always_ff @(posedge clk or posedge ff_reset) begin
      if (ff_reset) begin
         pos_reg    <= FLOOR_BOTTOM;
         cnt_reg    <= '0;
         arrive_reg <= 1'b0;
         moving_reg <= 1'b0;
         fault_reg  <= 1'b0;
      end else begin
         pos_reg    <= pos_next;
         cnt_reg    <= cnt_next;
         arrive_reg <= arrive_next;
         moving_reg <= moving_next;
         fault_reg  <= fault_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_sensor
         assign s_vec[gi] = aligned && (pos_reg == floor_t'(gi + 1));
      end
   endgenerate

   door_dwell_timer #(
      .DOOR_CYC (DOOR_CYC)
   ) u_door (
      .clk       (clk),
      .ff_reset  (ff_reset),
      .open      (open),
      .door_busy (door_busy)
   );

   assign s1     = s_vec[0];
   assign s2     = s_vec[1];
   assign s3     = s_vec[2];
   assign s4     = s_vec[3];
   assign pos    = pos_reg;
   assign arrive = arrive_reg;
   assign moving = moving_reg;
   assign fault  = fault_reg;

endmodule

// File: tb/tb_shaft_sensor_model.sv
// Scoreboard bench: the driver queues hand-derived expectations per edge, the monitor
// pops and compares one transaction after every rising clock edge.
module tb_shaft_sensor_model;
   import elev_pkg::*;

   localparam int TRAVEL = 8;
   localparam int DOOR   = 4;

   logic       clk = 1'b0;
   logic       ff_reset = 1'b1;
   logic [1:0] ac = AC_STOP;
   logic       open = 1'b0;
   logic       s1, s2, s3, s4, arrive, moving, door_busy, fault;
   logic [2:0] pos;

   always #5 clk = ~clk;

   shaft_sensor_model #(
      .TRAVEL_CYC (TRAVEL),
      .DOOR_CYC   (DOOR),
      .CNT_W      (4)
   ) dut (
      .clk       (clk),
      .ff_reset  (ff_reset),
      .ac        (ac),
      .open      (open),
      .s1        (s1),
      .s2        (s2),
      .s3        (s3),
      .s4        (s4),
      .arrive    (arrive),
      .pos       (pos),
      .moving    (moving),
      .door_busy (door_busy),
      .fault     (fault)
   );

   typedef struct {
      string      name;
      logic [3:0] s;
      logic       arr;
      logic [2:0] pos;
      logic       mov;
      logic       busy;
      logic       flt;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   done = 1'b0;

   // off is the absolute car offset in cycles from floor 1.
   function automatic exp_t mk(string n, int off, bit arr, bit mov, bit busy, bit flt);
      exp_t e;
      int   p;
      p      = off / TRAVEL + 1;
      e.name = n;
      e.pos  = 3'(p);
      e.s    = (off % TRAVEL == 0) ? 4'(1 << (p - 1)) : 4'b0000;
      e.arr  = arr;
      e.mov  = mov;
      e.busy = busy;
      e.flt  = flt;
      return e;
   endfunction

   task automatic cmp(string n, string f, logic [7:0] act, logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s actual=%0h required=%0h", n, f, act, req);
      end
   endtask

   task automatic compare_outputs(exp_t e);
      $display("txn %-16s s=%b%b%b%b arrive=%b pos=%0d moving=%b busy=%b fault=%b",
               e.name, s4, s3, s2, s1, arrive, pos, moving, door_busy, fault);
      cmp(e.name, "s",      8'({s4, s3, s2, s1}), 8'(e.s));
      cmp(e.name, "arrive", 8'(arrive),    8'(e.arr));
      cmp(e.name, "pos",    8'(pos),       8'(e.pos));
      cmp(e.name, "moving", 8'(moving),    8'(e.mov));
      cmp(e.name, "busy",   8'(door_busy), 8'(e.busy));
      cmp(e.name, "fault",  8'(fault),     8'(e.flt));
   endtask

   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         compare_outputs(q.pop_front());
      end
   end

   task automatic drive(logic [1:0] a, logic o, exp_t e);
      @(negedge clk);
      ac   = a;
      open = o;
      q.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", q.size());
         q.delete();
      end
   endtask

   task automatic finish_run();
      if (!done) begin
         done = 1'b1;
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
   endtask

   initial begin
      int off;
      ff_reset = 1'b1;
      repeat (2) @(negedge clk);
      compare_outputs(mk("reset", 0, 0, 0, 0, 0));
      ff_reset = 1'b0;
      drive(AC_STOP, 0, mk("idle", 0, 0, 0, 0, 0));

      // Floor 1 -> 3 with ac=up held.
      off = 0;
      for (int k = 1; k <= 16; k++) begin
         off++;
         drive(AC_UP, 0, mk($sformatf("up13_e%0d", k), off, off % TRAVEL == 0, 1, 0, 0));
      end
      // Reversal: three edges down from floor 3, three back up.
      for (int k = 1; k <= 3; k++) begin
         off--;
         drive(AC_DOWN, 0, mk($sformatf("rev_dn_e%0d", k), off, 0, 1, 0, 0));
      end
      for (int k = 1; k <= 3; k++) begin
         off++;
         drive(AC_UP, 0, mk($sformatf("rev_up_e%0d", k), off, k == 3, 1, 0, 0));
      end
      for (int k = 1; k <= 8; k++) begin
         off++;
         drive(AC_UP, 0, mk($sformatf("up34_e%0d", k), off, k == 8, 1, 0, 0));
      end
      // Overrun at the top.
      drive(AC_UP, 0, mk("top_overrun", 24, 0, 0, 0, 1));
      drive(AC_UP, 0, mk("top_hold", 24, 0, 0, 0, 1));
      for (int k = 1; k <= 24; k++) begin
         off--;
         drive(AC_DOWN, 0, mk($sformatf("dn41_e%0d", k), off, off % TRAVEL == 0, 1, 0, 1));
      end
      drain();

      @(negedge clk);
      ff_reset = 1'b1;
      #1;
      compare_outputs(mk("reset2", 0, 0, 0, 0, 0));
      @(negedge clk);
      ff_reset = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         drive(AC_DOWN, 0, mk($sformatf("bottom_idle_%0d", k), 0, 0, 0, 0, 0));
      end

      // Door dwell at floor 2.
      off = 0;
      for (int k = 1; k <= 8; k++) begin
         off++;
         drive(AC_UP, 0, mk($sformatf("up12_e%0d", k), off, k == 8, 1, 0, 0));
      end
      drive(AC_STOP, 1, mk("door_open", 8, 0, 0, 1, 0));
      for (int k = 1; k <= 3; k++) drive(AC_STOP, 0, mk($sformatf("dwell_%0d", k), 8, 0, 0, 1, 0));
      for (int k = 1; k <= 2; k++) drive(AC_STOP, 0, mk($sformatf("dwell_end_%0d", k), 8, 0, 0, 0, 0));
      for (int k = 1; k <= 3; k++) begin
         off++;
         drive(AC_UP, 0, mk($sformatf("up23_e%0d", k), off, 0, 1, 0, 0));
      end
      drive(AC_STOP, 1, mk("open_mid_seg", 11, 0, 0, 1, 1));
      drain();

      // Asynchronous reset mid-segment.
      @(negedge clk);
      open = 1'b0;
      #1;
      ff_reset = 1'b1;
      #1;
      compare_outputs(mk("async_reset", 0, 0, 0, 0, 0));
      @(negedge clk);
      ff_reset = 1'b0;
      drive(AC_ILLEGAL, 0, mk("illegal_ac_1", 0, 0, 0, 0, 1));
      drive(AC_ILLEGAL, 0, mk("illegal_ac_2", 0, 0, 0, 0, 1));
      drain();
      finish_run();
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog pending=%0d required=0", q.size());
      finish_run();
   end

endmodule
